// File: rtl/output_bram_stream_reader_if.sv
// Stream bundle for output_bram_stream_reader: data word, BRAM index,
// valid/ready handshake and end-of-job marker. master drives, slave accepts.
interface output_bram_stream_reader_if #(
  parameter int DW   = 16,
  parameter int ID_W = 4
);
  logic [DW-1:0]   tdata;
  logic [ID_W-1:0] tid;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (
    output tdata,
    output tid,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tid,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/output_bram_stream_reader.sv
// Drains output BRAM rows via the external read port into a holding
// buffer, then streams the words BRAM 0 first on a valid/ready stream.
// Ports: clk, rst_n (sync, active-low), start/base_addr/num_rows job
// request, busy/done status, ext_read_mode/ext_read_addr_flat to the BRAM
// bank, bram_read_data_flat from it, m = stream master (tdata/tid/tvalid/
// tready/tlast).
module output_bram_stream_reader #(
  parameter int DW        = 16,
  parameter int NUM_BRAMS = 16,
  parameter int O_ADDR_W  = 10,
  parameter int ID_W      = $clog2(NUM_BRAMS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [O_ADDR_W-1:0]           base_addr,
  input  logic [O_ADDR_W:0]             num_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          ext_read_mode,
  output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
  input  logic [NUM_BRAMS*DW-1:0]       bram_read_data_flat,
  output_bram_stream_reader_if.master   m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_BRAMS - 1);

  state_t state_q;
  state_t state_d;

  logic [O_ADDR_W-1:0] addr_q;
  logic [O_ADDR_W:0]   rows_q;
  logic [ID_W-1:0]     idx_q;
  logic [DW-1:0]       buf_q [NUM_BRAMS];

  logic hs;
  logic row_end;
  logic last_row;
  logic zero_job;

  logic [DW-1:0]   tdata;
  logic [ID_W-1:0] tid;
  logic            tvalid;
  logic            tlast;

  // rows_q counts rows still to send, including the one in flight
  assign hs       = (state_q == S_SHIFT) && m.tready;
  assign row_end  = hs && (idx_q == LAST_IDX);
  assign last_row = (rows_q == (O_ADDR_W+1)'(1));
  assign zero_job = (num_rows == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    busy               = 1'b0;
    done               = 1'b0;
    ext_read_mode      = 1'b0;
    ext_read_addr_flat = '0;
    tvalid             = 1'b0;
    tdata              = '0;
    tid                = '0;
    tlast              = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = zero_job ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy               = 1'b1;
        ext_read_mode      = 1'b1;
        ext_read_addr_flat = {NUM_BRAMS{addr_q}};
        state_d            = S_CAPT;
      end
      S_CAPT: begin
        busy               = 1'b1;
        ext_read_mode      = 1'b1;
        ext_read_addr_flat = {NUM_BRAMS{addr_q}};
        state_d            = S_SHIFT;
      end
      S_SHIFT: begin
        busy               = 1'b1;
        ext_read_mode      = 1'b1;
        ext_read_addr_flat = {NUM_BRAMS{addr_q}};
        tvalid             = 1'b1;
        tdata              = buf_q[idx_q];
        tid                = idx_q;
        tlast              = last_row && (idx_q == LAST_IDX);
        if (row_end) begin
          state_d = last_row ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m.tdata  = tdata;
  assign m.tid    = tid;
  assign m.tvalid = tvalid;
  assign m.tlast  = tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rows_q <= '0;
      idx_q  <= '0;
      for (int k = 0; k < NUM_BRAMS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !zero_job) begin
            addr_q <= base_addr;
            rows_q <= num_rows;
          end
        end
        S_CAPT: begin
          // read data for addr_q lands this cycle (1-cycle BRAM latency)
          for (int k = 0; k < NUM_BRAMS; k++) begin
            buf_q[k] <= bram_read_data_flat[k*DW +: DW];
          end
          idx_q <= '0;
        end
        S_SHIFT: begin
          if (hs) begin
            idx_q <= idx_q + 1'b1;
          end
          if (row_end && !last_row) begin
            addr_q <= addr_q + 1'b1;
            rows_q <= rows_q - 1'b1;
          end
        end
        S_ISSUE, S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_bram_stream_reader.sv
// Directed bench for output_bram_stream_reader: job table plus
// hand-written reset-mid-stream and start-while-busy sequences.
module tb_output_bram_stream_reader;
  localparam int DW = 16;
  localparam int NB = 16;
  localparam int AW = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_rows = '0;
  logic          busy;
  logic          done;
  logic          ext_read_mode;
  logic [NB*AW-1:0] ext_read_addr_flat;
  logic [NB*DW-1:0] bram_read_data_flat;

  output_bram_stream_reader_if #(.DW(DW), .ID_W(IW)) m_if ();

  output_bram_stream_reader #(
    .DW(DW), .NUM_BRAMS(NB), .O_ADDR_W(AW), .ID_W(IW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .base_addr          (base_addr),
    .num_rows           (num_rows),
    .busy               (busy),
    .done               (done),
    .ext_read_mode      (ext_read_mode),
    .ext_read_addr_flat (ext_read_addr_flat),
    .bram_read_data_flat(bram_read_data_flat),
    .m                  (m_if)
  );

  always #5 clk = ~clk;

  // word held by BRAM k at address a; addr 0 gives 0x0100+k
  function automatic logic [DW-1:0] fw(int k, logic [AW-1:0] a);
    return 16'h0100 + DW'(k) + {2'b00, a, 4'b0000};
  endfunction

  // BRAM bank model: 1-cycle registered read, per-slice address
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      bram_read_data_flat[k*DW +: DW] <= fw(k, ext_read_addr_flat[k*AW +: AW]);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] base;
    logic [AW:0]   rows;
    logic [3:0]    pat;
    int            mid_start;
    int            exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic run_job(input vec_t v);
    int c;
    int beats;
    int total;
    bit seen_mode;
    bit got_done;
    bit first_seen;
    logic [AW-1:0] ra;
    total = int'(v.rows) * NB;
    beats = 0;
    seen_mode = 0;
    got_done = 0;
    first_seen = 0;
    @(negedge clk);
    base_addr = v.base;
    num_rows = v.rows;
    start = 1'b1;
    m_if.tready = 1'b1;
    @(posedge clk);
    c = 1;
    while (c < 25000 && !got_done) begin
      @(negedge clk);
      start = (c == v.mid_start);
      if (start) begin
        base_addr = v.base + 10'd100;
        num_rows = 11'd5;
      end
      m_if.tready = v.pat[c % 4];
      ra = v.base + AW'(beats / NB);
      if (ext_read_mode) begin
        seen_mode = 1;
        chk({v.name, "_addr0"}, longint'(ext_read_addr_flat[AW-1:0]), longint'(ra));
        chk({v.name, "_addr15"},
            longint'(ext_read_addr_flat[(NB-1)*AW +: AW]), longint'(ra));
      end
      if (m_if.tvalid) begin
        if (!first_seen) begin
          first_seen = 1;
          chk({v.name, "_first_valid_cycle"}, c, 3);
        end
        chk({v.name, "_tdata"}, longint'(m_if.tdata), longint'(fw(beats % NB, ra)));
        chk({v.name, "_tid"}, longint'(m_if.tid), beats % NB);
        chk({v.name, "_tlast"}, longint'(m_if.tlast), longint'(beats == total - 1));
        if (m_if.tready) beats++;
      end
      if (done) begin
        got_done = 1;
        if (v.exp_done >= 0) chk({v.name, "_done_cycle"}, c, v.exp_done);
        chk({v.name, "_busy_at_done"}, longint'(busy), 0);
        chk({v.name, "_beats"}, beats, total);
      end
      c++;
    end
    if (!got_done) begin
      failures++;
      $display("FAIL %s_timeout: no done after %0d cycles, beats %0d of %0d",
               v.name, c, beats, total);
    end
    chk({v.name, "_mode_seen"}, longint'(seen_mode), longint'(v.rows != 0));
    start = 1'b0;
    @(negedge clk);
    chk({v.name, "_idle_after"}, longint'({done, busy, m_if.tvalid}), 0);
  endtask

  task automatic chk_all_zero(string name);
    chk({name, "_ctl"},
        longint'({busy, done, ext_read_mode, m_if.tvalid, m_if.tlast}), 0);
    chk({name, "_tdata"}, longint'(m_if.tdata), 0);
    chk({name, "_tid"}, longint'(m_if.tid), 0);
    chk({name, "_addr_zero"}, longint'(ext_read_addr_flat == '0), 1);
  endtask

  initial begin
    int n;
    bit done_seen;
    vecs[0] = '{"single",   10'd0,    11'd1,    4'b1111, 0,  19};
    vecs[1] = '{"wrap",     10'd1022, 11'd3,    4'b1111, 0,  55};
    vecs[2] = '{"bp",       10'd5,    11'd1,    4'b1001, 0,  33};
    vecs[3] = '{"zero",     10'd0,    11'd0,    4'b1111, 0,  1};
    vecs[4] = '{"midstart", 10'd7,    11'd1,    4'b1111, 10, 19};
    vecs[5] = '{"wrap_bp",  10'd1023, 11'd2,    4'b1001, 0,  -1};
    vecs[6] = '{"full",     10'd512,  11'd1024, 4'b1111, 0,  18433};

    m_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i]);
    end

    @(negedge clk);
    base_addr = 10'd3;
    num_rows = 11'd2;
    start = 1'b1;
    m_if.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(m_if.tvalid && m_if.tid == 4'd6)) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_beat7", longint'(m_if.tvalid && m_if.tid == 4'd6), 1);
    chk("rst_beat7_data", longint'(m_if.tdata), longint'(fw(6, 10'd3)));
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    chk("no_done_after_reset", longint'(done_seen), 0);
    vecs[0].name = "after_rst";
    run_job(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/output_bram_stream_reader.md
# output_bram_stream_reader

Drains computed results from the output BRAM bank through the accelerator's external read interface and streams them to the host side as a valid/ready word stream. The block sits outside the conv/transconv super top level. It drives that level's `ext_read_mode` / `ext_read_addr_flat` inputs and consumes `bram_read_data_flat`, so it is the reading end of the external read port. Each address is fetched from all BRAMs in parallel into a holding buffer, then serialized BRAM 0 first.

## Interface
- `DW`, 16, data word width
- `NUM_BRAMS`, 16, number of output BRAMs (power of two, ≥2)
- `O_ADDR_W`, 10, output BRAM address width
- `ID_W`, `$clog2(NUM_BRAMS)`, width of BRAM index sideband

- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_addr` input O_ADDR_W: first row address; latched on accepted `start`.
- `num_rows` input O_ADDR_W+1: rows to read, 0..2^O_ADDR_W; latched on accepted `start`.
- `busy` output 1: high in ISSUE/CAPT/SHIFT.
- `done` output 1: one-cycle pulse at job end.
- `ext_read_mode` output 1: drives the external read-mode select.
- `ext_read_addr_flat` output NUM_BRAMS*O_ADDR_W: current row address replicated in every slice.
- `bram_read_data_flat` input NUM_BRAMS*DW: BRAM read data; slice k = BRAM k.
- `m_tdata` output DW: stream word.
- `m_tid` output ID_W: BRAM index of `m_tdata`.
- `m_tvalid` output 1: word valid.
- `m_tready` input 1: sink accepts.
- `m_tlast` output 1: last word of job.

## Operation
- States: IDLE, ISSUE, CAPT, SHIFT, DONE.
- IDLE:
  - On `start`=1 with `num_rows`≠0: latch base and count, set address register to `base_addr`, go to ISSUE.
  - On `start`=1 with `num_rows`=0: go to DONE directly, emitting no beats.
- ISSUE: `ext_read_mode`=1 and address driven. Go to CAPT.
- CAPT: `bram_read_data_flat` is valid this cycle (BRAM read latency is 1 cycle). Capture all NUM_BRAMS words into the holding buffer at the clock edge, clear word index to 0, go to SHIFT.
- SHIFT:
  - `m_tvalid`=1, `m_tdata`=buffer[index], `m_tid`=index.
  - On handshake (`m_tvalid`&`m_tready`), increment index.
  - On the handshake of index NUM_BRAMS-1: if rows remain, increment address (mod 2^O_ADDR_W, wraps 1023→0) and go to ISSUE; else go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `m_tlast`=1 only when index=NUM_BRAMS-1 on the final row.
- `ext_read_mode`=1 in ISSUE, CAPT and SHIFT; 0 in IDLE and DONE. The address stays stable while `ext_read_mode`=1.
- `start` outside IDLE is ignored. There is no queuing.
- The holding buffer is not rewritten in SHIFT, so data is stable under backpressure.
- Row counter is O_ADDR_W+1 bits so that a full-depth job (2^O_ADDR_W rows) is legal and wraps back to `base_addr`.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: all outputs 0, state IDLE.
- `rst_n`=0 in any state, including mid-stream: next edge forces IDLE and all outputs 0. A partially sent row is discarded and no `done` is emitted.
- For `start` accepted at edge 0:
  - ISSUE occupies cycle 1, CAPT cycle 2.
  - First `m_tvalid` is in cycle 3.
  - With `m_tready` held 1, words go out in cycles 3..18, next ISSUE is in cycle 19.
  - Sustained throughput is NUM_BRAMS words per NUM_BRAMS+2 cycles.
- `done` is high the cycle after the final handshake; `busy` is 0 in that cycle.
- A job with `num_rows`=0 gives `done` in cycle 1 after the accepting edge, with no `ext_read_mode` assertion.
- `m_tvalid` never deasserts once raised until its handshake, and data/id/last hold while `m_tready`=0.
- `m_tdata` is the signed two's-complement slice unchanged. No width conversion.

## Test plan
- **Single row:** BRAM k at addr 0 preloaded with 0x0100+k; start, base=0, rows=1, `m_tready`=1 → 16 beats 0x0100..0x010F, `m_tid` 0..15, `m_tlast` on beat 16 (cycle 18), `done` cycle 19.
- **Wrap-around:** base=1022, rows=3 → `ext_read_addr_flat` slices show 1022, 1023, 0 in successive ISSUE phases; 48 beats in row order; `m_tlast` only on beat 48.
- **Backpressure:** `m_tready` pattern 1,0,0,1 repeating → `m_tdata`/`m_tid` stable while stalled, no beat lost or duplicated, 16 accepted words match preload.
- **Zero length and start while busy:**
  - rows=0 → `done` one cycle after start, no `m_tvalid`, `ext_read_mode` stays 0.
  - Second `start` pulsed mid-job → ignored; beat count equals the first job only.
- **Reset mid-stream:** assert `rst_n`=0 during beat 7 → next edge all outputs 0 and state IDLE; a new job afterwards runs correctly from beat 1.
